dest_ip_filter_tcam: RTL and testbench
======================================

Name: dest_ip_filter_tcam

Overview:
Parametrised destination-IP filter for the router output-port-lookup stage, generalising the fixed 32-entry exact-match CAM filter.
- Holds LUT_DEPTH ternary entries (IP, don't-care mask, valid) in flops, with no external CAM.
- Extracts the IPv4 destination from the header word stream and matches it against all entries in a 2-stage pipeline.
- Queues {hit, index} results to the process block, with hit/miss statistics and overflow detection.

Parameters:
DATA_WIDTH, 64, header word width (>=64)
LUT_DEPTH, 32, number of table entries (1..64)
LUT_DEPTH_BITS, log2(LUT_DEPTH), entry index width (min 1)
RESULT_FIFO_DEPTH_BITS, 2, result queue depth = 2**N
CNT_WIDTH, 32, hit/miss counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_data  in  DATA_WIDTH  header word
word_IP_SRC_DST  in  1  in_data[15:0] = dst IP [31:16]
word_IP_DST_LO  in  1  in_data[DATA_WIDTH-1 -:16] = dst IP [15:0]; triggers lookup
dest_ip_hit  out  1  head-of-queue hit flag
dest_ip_hit_index  out  LUT_DEPTH_BITS  head-of-queue matching entry (0 on miss)
dest_ip_filter_vld  out  1  queue not empty
rd_dest_ip_filter_result  in  1  pop head of queue
dest_ip_filter_rd_addr  in  LUT_DEPTH_BITS  table read address
dest_ip_filter_rd_req  in  1  read request pulse
dest_ip_filter_rd_ip  out  32  entry IP
dest_ip_filter_rd_mask  out  32  entry mask (1 = don't care)
dest_ip_filter_rd_vld  out  1  entry valid bit
dest_ip_filter_rd_ack  out  1  read ack pulse
dest_ip_filter_wr_addr  in  LUT_DEPTH_BITS  table write address
dest_ip_filter_wr_req  in  1  write request pulse
dest_ip_filter_wr_ip  in  32  IP to store
dest_ip_filter_wr_mask  in  32  mask to store
dest_ip_filter_wr_vld  in  1  valid bit to store (0 = delete entry)
dest_ip_filter_wr_ack  out  1  write ack pulse
hit_count  out  CNT_WIDTH  saturating lookup-hit count
miss_count  out  CNT_WIDTH  saturating lookup-miss count
result_overflow  out  1  sticky: result dropped because queue full

Behaviour:
Reset (reset_n low, async):
- All outputs 0.
- All entries invalid, with IP and mask 0.
- Queue empty; counters 0; result_overflow 0.
- Any in-flight lookup is discarded.

Key capture:
- On word_IP_SRC_DST, key[31:16] <= in_data[15:0].
- On word_IP_DST_LO, key[15:0] <= in_data[DATA_WIDTH-1 -:16] and key_vld <= 1 for exactly one cycle.
- Both strobes in the same cycle update both halves.

Pipeline:
- Let the word_IP_DST_LO cycle be T.
- T+1: compare. match[i] = vld[i] & (((key ^ ip[i]) & ~mask[i]) == 0). Register the match vector plus a stage valid bit.
- T+2: priority-encode the lowest matching index and push {hit = |match, index} into the queue; dest_ip_filter_vld is seen high from T+3.
- Back-to-back lookups, one per cycle, are fully pipelined.

Result queue:
- Fallthrough FIFO: dest_ip_hit and dest_ip_hit_index are valid whenever dest_ip_filter_vld=1.
- Pop on rd_dest_ip_filter_result; a pop while empty is ignored.
- Push while full with no pop in the same cycle: result is dropped and result_overflow sets; it clears only by reset.
- Push and pop in the same cycle while full is legal and drops nothing.

Counters:
- On each push attempt (including dropped ones), hit_count or miss_count increments.
- Counters saturate at all-ones and never wrap.

Table write:
- On wr_req at cycle W, the entry at wr_addr is updated at the end of W; wr_ack pulses in W+1.
- The compare in cycle W uses the old contents; compares from W+1 use the new contents.
- wr_addr >= LUT_DEPTH: no update, ack still issued.

Table read:
- On rd_req at cycle R, rd_ip, rd_mask and rd_vld are registered at the end of R; rd_ack pulses in R+1.
- Read data holds until the next read.
- Simultaneous read and write to the same address returns the old contents.
- rd_addr >= LUT_DEPTH returns zeros.

Mask 0xFFFFFFFF on a valid entry matches every key (default route/catch-all).

Decomposition:
- Shared package (dest_ip_filter_pkg): IP_WIDTH=32, result struct/width {hit, index}, and the log2 function.
- Sub-module: lowest_index_prio_enc (LUT_DEPTH-wide vector in, {any, index} out, combinational).
- The result queue reuses the existing fallthrough_small_fifo.

Test Plan:
1. Write entry 3 = 10.0.1.5, mask 0, vld 1 (wr_ack after 1 cycle). Send header with dst 10.0.1.5 -> dest_ip_filter_vld at T+3, hit=1, index=3, hit_count=1.
2. Entry 5 = 10.0.0.0 mask 0x00FFFFFF, entry 7 = 10.0.1.0 mask 0x000000FF; lookup 10.0.1.9 -> hit index 5 (lowest wins). Delete entry 5, repeat -> index 7.
3. Four back-to-back lookups (3 hits, 1 miss), no pops -> queue full, results in order. Fifth lookup -> result dropped, result_overflow=1, miss_count or hit_count still increments.
4. Write entry 2 in the same cycle its compare occurs for a matching key -> that lookup misses; the next identical lookup hits index 2.
5. Read and write entry 4 in the same cycle -> rd_ack returns the old IP/mask; the next read returns the new values.
6. Assert reset_n low with two results queued and one lookup in flight -> dest_ip_filter_vld=0 immediately, all entries invalid, counters 0, no late push after release.

Source files
------------

// File: rtl/dest_ip_filter_pkg.sv
// dest_ip_filter_pkg
// Shared definitions for the destination-IP TCAM filter:
//   IP_WIDTH       - width of an IPv4 address
//   MAX_INDEX_BITS - widest entry index the filter supports (64 entries)
//   result_t       - {hit, index} record carried through the result queue
//   log2_min1()    - index width for a given table depth, never below 1
package dest_ip_filter_pkg;

  localparam int IP_WIDTH       = 32;
  localparam int MAX_INDEX_BITS = 6;

  // The index field is sized for the largest table so the queue word is fixed;
  // smaller tables zero-extend into it.
  typedef struct packed {
    logic                      hit;
    logic [MAX_INDEX_BITS-1:0] index;
  } result_t;

  localparam int RESULT_WIDTH = $bits(result_t);

  function automatic int log2_min1(input int n);
    int bits;
    bits = 1;
    while ((1 << bits) < n) bits = bits + 1;
    return bits;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo
// Small first-word-fallthrough FIFO: dout shows the head entry whenever the
// FIFO is not empty. Writes into a full FIFO are discarded unless a read
// happens in the same cycle; reads from an empty FIFO are ignored.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   din, wr_en    write data and write strobe
//   rd_en         pop the head entry
//   dout          head entry (undefined while empty)
//   full, empty   occupancy flags
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = MAX_DEPTH_BITS'(1);
  localparam logic [MAX_DEPTH_BITS:0]   DEPTH_ONE = (MAX_DEPTH_BITS + 1)'(1);
  localparam logic [MAX_DEPTH_BITS:0]   DEPTH_MAX = (MAX_DEPTH_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      do_wr;
  logic                      do_rd;

  assign full  = (depth == DEPTH_MAX);
  assign empty = (depth == '0);
  assign do_rd = rd_en & ~empty;
  // A simultaneous pop frees the slot, so a write into a full FIFO is kept.
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + DEPTH_ONE;
        2'b01:   depth <= depth - DEPTH_ONE;
        default: depth <= depth;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until a write has landed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lowest_index_prio_enc.sv
// lowest_index_prio_enc
// Combinational priority encoder: reports whether any bit of vec is set and
// the index of the lowest set bit (0 when none is set).
// Ports:
//   vec   in  WIDTH       request vector
//   any   out 1           at least one bit set
//   index out INDEX_BITS  lowest set bit position
module lowest_index_prio_enc
  import dest_ip_filter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = log2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0]      vec,
  output logic                  any,
  output logic [INDEX_BITS-1:0] index
);

  // Scanning from the top down lets the lowest set bit overwrite any higher one.
  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any   = 1'b1;
        index = INDEX_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/dest_ip_filter_tcam.sv
// dest_ip_filter_tcam
// Flop-based ternary destination-IP filter for the output-port-lookup stage.
// The destination address is assembled from two header words, compared
// against every table entry (IP, don't-care mask, valid), and the lowest
// matching index is queued as {hit, index} for the process block.
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   in_data, word_IP_SRC_DST,
//   word_IP_DST_LO               header word and the strobes marking the
//                                words holding dst IP [31:16] and [15:0]
//   dest_ip_hit(_index),
//   dest_ip_filter_vld,
//   rd_dest_ip_filter_result     result queue head and pop
//   dest_ip_filter_rd_*          table read port (registered, ack pulse)
//   dest_ip_filter_wr_*          table write port (ack pulse)
//   hit_count, miss_count        saturating lookup statistics
//   result_overflow              sticky: a result was dropped on a full queue
module dest_ip_filter_tcam
  import dest_ip_filter_pkg::*;
#(
  parameter int DATA_WIDTH             = 64,
  parameter int LUT_DEPTH              = 32,
  parameter int LUT_DEPTH_BITS         = log2_min1(LUT_DEPTH),
  parameter int RESULT_FIFO_DEPTH_BITS = 2,
  parameter int CNT_WIDTH              = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      word_IP_SRC_DST,
  input  logic                      word_IP_DST_LO,
  output logic                      dest_ip_hit,
  output logic [LUT_DEPTH_BITS-1:0] dest_ip_hit_index,
  output logic                      dest_ip_filter_vld,
  input  logic                      rd_dest_ip_filter_result,
  input  logic [LUT_DEPTH_BITS-1:0] dest_ip_filter_rd_addr,
  input  logic                      dest_ip_filter_rd_req,
  output logic [IP_WIDTH-1:0]       dest_ip_filter_rd_ip,
  output logic [IP_WIDTH-1:0]       dest_ip_filter_rd_mask,
  output logic                      dest_ip_filter_rd_vld,
  output logic                      dest_ip_filter_rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0] dest_ip_filter_wr_addr,
  input  logic                      dest_ip_filter_wr_req,
  input  logic [IP_WIDTH-1:0]       dest_ip_filter_wr_ip,
  input  logic [IP_WIDTH-1:0]       dest_ip_filter_wr_mask,
  input  logic                      dest_ip_filter_wr_vld,
  output logic                      dest_ip_filter_wr_ack,
  output logic [CNT_WIDTH-1:0]      hit_count,
  output logic [CNT_WIDTH-1:0]      miss_count,
  output logic                      result_overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Lookup key and pipeline state
  logic [IP_WIDTH-1:0]       key;
  logic                      key_vld;
  logic [LUT_DEPTH-1:0]      match;
  logic [LUT_DEPTH-1:0]      match_q;
  logic                      match_vld;
  logic                      enc_any;
  logic [LUT_DEPTH_BITS-1:0] enc_index;

  // Table storage
  logic [IP_WIDTH-1:0]  tbl_ip   [LUT_DEPTH];
  logic [IP_WIDTH-1:0]  tbl_mask [LUT_DEPTH];
  logic [LUT_DEPTH-1:0] tbl_vld;

  // Read port selection
  logic [IP_WIDTH-1:0] rd_ip_sel;
  logic [IP_WIDTH-1:0] rd_mask_sel;
  logic                rd_vld_sel;

  // Result queue
  result_t                 push_res;
  result_t                 head;
  logic [RESULT_WIDTH-1:0] fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;

  // Only the two 16-bit address fields of the header word are consumed.
  logic unused_in_data;
  logic unused_head;
  assign unused_in_data = ^in_data;
  assign unused_head    = ^fifo_dout;

  // Key capture: the two halves may arrive in separate words or together;
  // key_vld marks the single cycle in which the completed key is compared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key     <= '0;
      key_vld <= 1'b0;
    end else begin
      key_vld <= word_IP_DST_LO;
      if (word_IP_SRC_DST) key[31:16] <= in_data[15:0];
      if (word_IP_DST_LO)  key[15:0]  <= in_data[DATA_WIDTH-1 -: 16];
    end
  end

  // Ternary compare: a set mask bit removes that bit from the comparison.
  always_comb begin
    match = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      match[i] = tbl_vld[i] & (((key ^ tbl_ip[i]) & ~tbl_mask[i]) == '0);
    end
  end

  // Compare stage register; reset discards any lookup in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q   <= '0;
      match_vld <= 1'b0;
    end else begin
      match_q   <= match;
      match_vld <= key_vld;
    end
  end

  lowest_index_prio_enc #(
    .WIDTH      (LUT_DEPTH),
    .INDEX_BITS (LUT_DEPTH_BITS)
  ) u_prio_enc (
    .vec   (match_q),
    .any   (enc_any),
    .index (enc_index)
  );

  // Table writes land at the clock edge ending the request cycle, so a compare
  // in that same cycle still sees the old entry. Out-of-range addresses match
  // no entry and therefore leave the table untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        tbl_ip[i]   <= '0;
        tbl_mask[i] <= '0;
      end
      tbl_vld               <= '0;
      dest_ip_filter_wr_ack <= 1'b0;
    end else begin
      dest_ip_filter_wr_ack <= dest_ip_filter_wr_req;
      if (dest_ip_filter_wr_req) begin
        for (int i = 0; i < LUT_DEPTH; i++) begin
          if (dest_ip_filter_wr_addr == LUT_DEPTH_BITS'(i)) begin
            tbl_ip[i]   <= dest_ip_filter_wr_ip;
            tbl_mask[i] <= dest_ip_filter_wr_mask;
            tbl_vld[i]  <= dest_ip_filter_wr_vld;
          end
        end
      end
    end
  end

  // Read mux; an address beyond the table selects nothing and yields zeros.
  always_comb begin
    rd_ip_sel   = '0;
    rd_mask_sel = '0;
    rd_vld_sel  = 1'b0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (dest_ip_filter_rd_addr == LUT_DEPTH_BITS'(i)) begin
        rd_ip_sel   = tbl_ip[i];
        rd_mask_sel = tbl_mask[i];
        rd_vld_sel  = tbl_vld[i];
      end
    end
  end

  // Read data is sampled from pre-write contents and held until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dest_ip_filter_rd_ip   <= '0;
      dest_ip_filter_rd_mask <= '0;
      dest_ip_filter_rd_vld  <= 1'b0;
      dest_ip_filter_rd_ack  <= 1'b0;
    end else begin
      dest_ip_filter_rd_ack <= dest_ip_filter_rd_req;
      if (dest_ip_filter_rd_req) begin
        dest_ip_filter_rd_ip   <= rd_ip_sel;
        dest_ip_filter_rd_mask <= rd_mask_sel;
        dest_ip_filter_rd_vld  <= rd_vld_sel;
      end
    end
  end

  assign push           = match_vld;
  assign pop            = rd_dest_ip_filter_result & ~fifo_empty;
  assign push_res.hit   = enc_any;
  assign push_res.index = MAX_INDEX_BITS'(enc_index);

  fallthrough_small_fifo #(
    .WIDTH          (RESULT_WIDTH),
    .MAX_DEPTH_BITS (RESULT_FIFO_DEPTH_BITS)
  ) u_result_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (push_res),
    .wr_en   (push),
    .rd_en   (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head outputs are forced to zero while the queue is empty so the unwritten
  // storage never leaks out.
  assign head               = result_t'(fifo_dout);
  assign dest_ip_filter_vld = ~fifo_empty;
  assign dest_ip_hit        = head.hit & ~fifo_empty;
  assign dest_ip_hit_index  = LUT_DEPTH_BITS'(head.index) & {LUT_DEPTH_BITS{~fifo_empty}};

  // Statistics count every push attempt, including results the queue drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count       <= '0;
      miss_count      <= '0;
      result_overflow <= 1'b0;
    end else begin
      if (push) begin
        if (enc_any) begin
          if (hit_count != '1) hit_count <= hit_count + CNT_ONE;
        end else begin
          if (miss_count != '1) miss_count <= miss_count + CNT_ONE;
        end
      end
      if (push && fifo_full && !pop) result_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dest_ip_filter_tcam.sv
// tb_dest_ip_filter_tcam
// Directed self-checking bench for dest_ip_filter_tcam. Expected lookup
// results go into a scoreboard queue when a lookup is driven and are popped
// when the DUT presents them. The table is 24 entries deep so that
// out-of-range addresses are reachable, and counters are 3 bits wide so
// saturation is reachable.
module tb_dest_ip_filter_tcam;
  import dest_ip_filter_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 24;
  localparam int IDXW  = 5;
  localparam int FBITS = 2;
  localparam int CW    = 3;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [DW-1:0]   in_data;
  logic            word_src;
  logic            word_lo;
  logic            hit;
  logic [IDXW-1:0] hit_index;
  logic            filter_vld;
  logic            rd_result;
  logic [IDXW-1:0] rd_addr;
  logic            rd_req;
  logic [31:0]     rd_ip;
  logic [31:0]     rd_mask;
  logic            rd_vld;
  logic            rd_ack;
  logic [IDXW-1:0] wr_addr;
  logic            wr_req;
  logic [31:0]     wr_ip;
  logic [31:0]     wr_mask;
  logic            wr_vld;
  logic            wr_ack;
  logic [CW-1:0]   hit_count;
  logic [CW-1:0]   miss_count;
  logic            overflow;

  typedef struct packed {
    logic            hit;
    logic [IDXW-1:0] index;
  } exp_t;

  exp_t          sb[$];
  int            checkCount = 0;
  int            failCount  = 0;
  logic [CW-1:0] expHits    = '0;
  logic [CW-1:0] expMisses  = '0;

  always #5 clk = ~clk;

  dest_ip_filter_tcam #(
    .DATA_WIDTH             (DW),
    .LUT_DEPTH              (DEPTH),
    .LUT_DEPTH_BITS         (IDXW),
    .RESULT_FIFO_DEPTH_BITS (FBITS),
    .CNT_WIDTH              (CW)
  ) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .in_data                  (in_data),
    .word_IP_SRC_DST          (word_src),
    .word_IP_DST_LO           (word_lo),
    .dest_ip_hit              (hit),
    .dest_ip_hit_index        (hit_index),
    .dest_ip_filter_vld       (filter_vld),
    .rd_dest_ip_filter_result (rd_result),
    .dest_ip_filter_rd_addr   (rd_addr),
    .dest_ip_filter_rd_req    (rd_req),
    .dest_ip_filter_rd_ip     (rd_ip),
    .dest_ip_filter_rd_mask   (rd_mask),
    .dest_ip_filter_rd_vld    (rd_vld),
    .dest_ip_filter_rd_ack    (rd_ack),
    .dest_ip_filter_wr_addr   (wr_addr),
    .dest_ip_filter_wr_req    (wr_req),
    .dest_ip_filter_wr_ip     (wr_ip),
    .dest_ip_filter_wr_mask   (wr_mask),
    .dest_ip_filter_wr_vld    (wr_vld),
    .dest_ip_filter_wr_ack    (wr_ack),
    .hit_count                (hit_count),
    .miss_count               (miss_count),
    .result_overflow          (overflow)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one lookup; split sends the upper address half in a preceding word.
  // queued=0 marks a result the full queue is expected to drop.
  task automatic applyStimulus(input logic [31:0] ip, input bit split,
                               input bit expHit, input int expIdx, input bit queued);
    exp_t e;
    if (split) begin
      in_data        = '0;
      in_data[15:0]  = ip[31:16];
      word_src       = 1'b1;
      tick();
      word_src       = 1'b0;
    end
    in_data = '0;
    if (!split) in_data[15:0] = ip[31:16];
    in_data[DW-1 -: 16] = ip[15:0];
    word_src = !split;
    word_lo  = 1'b1;
    tick();
    word_src = 1'b0;
    word_lo  = 1'b0;
    in_data  = '0;
    e.hit   = expHit;
    e.index = IDXW'(expIdx);
    if (queued) sb.push_back(e);
    if (expHit) begin
      if (expHits != CNT_MAX) expHits++;
    end else begin
      if (expMisses != CNT_MAX) expMisses++;
    end
  endtask

  task automatic popResult(input string tag);
    exp_t e;
    int waited = 0;
    while (!filter_vld && waited < 8) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_vld"}, 64'(filter_vld), 64'd1);
    if (filter_vld) begin
      if (sb.size() == 0) begin
        checkCount++;
        failCount++;
        $error("[TB] FAIL %s_unexpected: observed result hit=%0d idx=%0d expected none", tag, hit, hit_index);
      end else begin
        e = sb.pop_front();
        checkOutput({tag, "_hit"}, 64'(hit), 64'(e.hit));
        checkOutput({tag, "_idx"}, 64'(hit_index), 64'(e.index));
      end
      rd_result = 1'b1;
      tick();
      rd_result = 1'b0;
    end
  endtask

  task automatic writeEntry(input int addr, input logic [31:0] ip,
                            input logic [31:0] mask, input bit vld);
    wr_addr = IDXW'(addr);
    wr_ip   = ip;
    wr_mask = mask;
    wr_vld  = vld;
    wr_req  = 1'b1;
    tick();
    wr_req  = 1'b0;
    checkOutput($sformatf("wr_ack_%0d", addr), 64'(wr_ack), 64'd1);
  endtask

  task automatic readEntry(input int addr, input logic [31:0] ip,
                           input logic [31:0] mask, input bit vld);
    rd_addr = IDXW'(addr);
    rd_req  = 1'b1;
    tick();
    rd_req  = 1'b0;
    checkOutput($sformatf("rd_ack_%0d", addr), 64'(rd_ack), 64'd1);
    checkOutput($sformatf("rd_ip_%0d", addr), 64'(rd_ip), 64'(ip));
    checkOutput($sformatf("rd_mask_%0d", addr), 64'(rd_mask), 64'(mask));
    checkOutput($sformatf("rd_vld_%0d", addr), 64'(rd_vld), 64'(vld));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    word_src  = 1'b0;
    word_lo   = 1'b0;
    rd_result = 1'b0;
    rd_addr   = '0;
    rd_req    = 1'b0;
    wr_addr   = '0;
    wr_req    = 1'b0;
    wr_ip     = '0;
    wr_mask   = '0;
    wr_vld    = 1'b0;
    tick();
    tick();
    checkOutput("rst_vld", 64'(filter_vld), 64'd0);
    checkOutput("rst_hit", 64'(hit), 64'd0);
    checkOutput("rst_idx", 64'(hit_index), 64'd0);
    checkOutput("rst_hits", 64'(hit_count), 64'd0);
    checkOutput("rst_miss", 64'(miss_count), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkOutput("rst_acks", 64'({rd_ack, wr_ack}), 64'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] exact match and result latency");
    writeEntry(3, 32'h0A00_0105, 32'h0, 1'b1);
    tick();
    checkOutput("wr_ack_pulse", 64'(wr_ack), 64'd0);
    applyStimulus(32'h0A00_0105, 1'b1, 1'b1, 3, 1'b1);
    checkOutput("lat_t1", 64'(filter_vld), 64'd0);
    tick();
    checkOutput("lat_t2", 64'(filter_vld), 64'd0);
    tick();
    checkOutput("lat_t3", 64'(filter_vld), 64'd1);
    popResult("t1");
    checkOutput("t1_hits", 64'(hit_count), 64'(expHits));

    $display("[TB] overlapping masks, lowest index wins");
    writeEntry(5, 32'h0A00_0000, 32'h00FF_FFFF, 1'b1);
    writeEntry(7, 32'h0A00_0100, 32'h0000_00FF, 1'b1);
    applyStimulus(32'h0A00_0109, 1'b0, 1'b1, 5, 1'b1);
    popResult("t2a");
    writeEntry(5, 32'h0A00_0000, 32'h00FF_FFFF, 1'b0);
    applyStimulus(32'h0A00_0109, 1'b0, 1'b1, 7, 1'b1);
    popResult("t2b");
    checkOutput("t2_hits", 64'(hit_count), 64'(expHits));
    checkOutput("t2_ovf", 64'(overflow), 64'd0);

    $display("[TB] out-of-range table address");
    writeEntry(30, 32'h0808_0808, 32'h0, 1'b1);
    readEntry(30, 32'h0, 32'h0, 1'b0);
    applyStimulus(32'h0808_0808, 1'b0, 1'b0, 0, 1'b1);
    popResult("oor");

    $display("[TB] back-to-back lookups fill the queue");
    applyStimulus(32'h0A00_0105, 1'b0, 1'b1, 3, 1'b1);
    applyStimulus(32'h0A00_0109, 1'b0, 1'b1, 7, 1'b1);
    applyStimulus(32'hC0A8_0001, 1'b0, 1'b0, 0, 1'b1);
    applyStimulus(32'h0A00_01C8, 1'b0, 1'b1, 7, 1'b1);
    applyStimulus(32'h0A00_0105, 1'b0, 1'b1, 3, 1'b0);
    repeat (3) tick();
    checkOutput("t3_ovf", 64'(overflow), 64'd1);
    checkOutput("t3_hits", 64'(hit_count), 64'(expHits));
    checkOutput("t3_miss", 64'(miss_count), 64'(expMisses));
    for (int i = 0; i < 4; i++) popResult($sformatf("t3_%0d", i));
    checkOutput("t3_drained", 64'(filter_vld), 64'd0);

    $display("[TB] write during compare cycle");
    applyStimulus(32'hAC10_0001, 1'b0, 1'b0, 0, 1'b1);
    writeEntry(2, 32'hAC10_0001, 32'h0, 1'b1);
    applyStimulus(32'hAC10_0001, 1'b0, 1'b1, 2, 1'b1);
    popResult("t4a");
    popResult("t4b");
    checkOutput("t4_hits_sat", 64'(hit_count), 64'(expHits));
    checkOutput("t4_miss", 64'(miss_count), 64'(expMisses));

    $display("[TB] catch-all entry");
    writeEntry(10, 32'h0, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(32'h0808_0808, 1'b0, 1'b1, 10, 1'b1);
    applyStimulus(32'h0A00_0105, 1'b0, 1'b1, 3, 1'b1);
    popResult("ca_a");
    popResult("ca_b");
    checkOutput("ca_hits_sat", 64'(hit_count), 64'(expHits));

    $display("[TB] simultaneous read and write");
    writeEntry(4, 32'h0102_0304, 32'h0000_FFFF, 1'b1);
    rd_addr = IDXW'(4);
    rd_req  = 1'b1;
    wr_addr = IDXW'(4);
    wr_ip   = 32'h0506_0708;
    wr_mask = 32'h0000_00FF;
    wr_vld  = 1'b1;
    wr_req  = 1'b1;
    tick();
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    checkOutput("t5_rd_ack", 64'(rd_ack), 64'd1);
    checkOutput("t5_wr_ack", 64'(wr_ack), 64'd1);
    checkOutput("t5_old_ip", 64'(rd_ip), 64'h0102_0304);
    checkOutput("t5_old_mask", 64'(rd_mask), 64'h0000_FFFF);
    tick();
    checkOutput("t5_ack_drop", 64'(rd_ack), 64'd0);
    checkOutput("t5_hold_ip", 64'(rd_ip), 64'h0102_0304);
    readEntry(4, 32'h0506_0708, 32'h0000_00FF, 1'b1);

    $display("[TB] reset with results queued and in flight");
    applyStimulus(32'h0A00_0105, 1'b0, 1'b1, 3, 1'b1);
    applyStimulus(32'h0A00_0109, 1'b0, 1'b1, 7, 1'b1);
    applyStimulus(32'h0808_0808, 1'b0, 1'b1, 10, 1'b1);
    tick();
    checkOutput("t6_pre_vld", 64'(filter_vld), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_vld", 64'(filter_vld), 64'd0);
    checkOutput("t6_hit", 64'(hit), 64'd0);
    checkOutput("t6_hits", 64'(hit_count), 64'd0);
    checkOutput("t6_miss", 64'(miss_count), 64'd0);
    checkOutput("t6_ovf", 64'(overflow), 64'd0);
    sb.delete();
    expHits   = '0;
    expMisses = '0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("t6_no_push_%0d", i), 64'(filter_vld), 64'd0);
    end
    checkOutput("t6_hits_post", 64'(hit_count), 64'd0);
    readEntry(3, 32'h0, 32'h0, 1'b0);
    readEntry(10, 32'h0, 32'h0, 1'b0);
    applyStimulus(32'h0A00_0105, 1'b0, 1'b0, 0, 1'b1);
    popResult("t6_post");
    checkOutput("t6_miss_post", 64'(miss_count), 64'(expMisses));

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
